calc_seq_ctrl: RTL and testbench
================================

CALC_SEQ_CTRL -- requirements
Module: calc_seq_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 2, multiplier wait cycles between issue and result load; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYC, default 255, max wait cycles on done_calc/done_div; legal range 1..65535.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 go  in  1  start request; rising-edge qualified.
REQ-006 f  in  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 inc, 101 dec, 110 square, 111 illegal.
REQ-007 done_calc  in  1  add/sub unit result valid; done_div  in  1  divider result valid; err_div  in  1  divider error (divide by zero).
REQ-008 en_f, en_x, en_y  out  1 each  operand/opcode register load enables.
REQ-009 go_calc, go_div  out  1 each  unit start pulses.
REQ-010 op_calc  out  2  00 add, 01 sub, 10 inc, 11 dec.
REQ-011 sel_square  out  1  multiplier B operand: 0 Y, 1 X.
REQ-012 sel_h  out  1 and sel_l  out  2  output mux selects; en_out_h, en_out_l  out  1 each  output register loads.
REQ-013 done  out  1  completion pulse; busy  out  1  operation in flight; error  out  1  sticky fault flag; cs  out  4  current state.

Function
REQ-014 States and encodings: IDLE 0, LOAD 1, DECODE 2, CALC_GO 3, CALC_WAIT 4, MUL_SET 5, MUL_WAIT 6, MUL_LOAD 7, DIV_GO 8, DIV_WAIT 9, DONE 10, ERROR 11; codes 12-15 SHALL go to IDLE on the next cycle.
REQ-015 IDLE->LOAD only when go=1 and go was 0 in the previous cycle; a go held high SHALL NOT retrigger.
REQ-016 LOAD: en_f=en_x=en_y=1 for one cycle; f captured into internal f_q; error cleared; next state DECODE.
REQ-017 DECODE on f_q: add/sub/inc/dec->CALC_GO; mul/square->MUL_SET; div->DIV_GO; 111->ERROR.
REQ-018 op_calc SHALL be decoded from f_q, held constant from DECODE through CALC_WAIT, and 00 in all other states.
REQ-019 CALC_GO: go_calc=1 for exactly one cycle, then CALC_WAIT.
REQ-020 CALC_WAIT: on done_calc=1, sel_l=01 and en_out_l=1 in that same cycle, then DONE; otherwise stay.
REQ-021 MUL_SET: sel_square=1 for square, 0 for mul; sel_square held through MUL_LOAD; internal counter loaded with MUL_LAT-1.
REQ-022 MUL_WAIT: decrement the counter each cycle; leave for MUL_LOAD in the cycle the counter reads 0, giving exactly MUL_LAT cycles in MUL_WAIT.
REQ-023 MUL_LOAD: sel_h=0, sel_l=10, en_out_h=en_out_l=1 for one cycle, then DONE.
REQ-024 DIV_GO: go_div=1 for exactly one cycle, then DIV_WAIT.
REQ-025 DIV_WAIT: err_div=1 has priority and goes to ERROR with no output load; else done_div=1 drives sel_h=1, sel_l=11, en_out_h=en_out_l=1 that cycle, then DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 ERROR: error set to 1 (sticky until next LOAD or reset); one cycle, then IDLE; done stays 0.
REQ-028 busy=1 in every state except IDLE; go during busy is ignored.
REQ-029 All unlisted outputs SHALL be 0 in every state.
REQ-030 Outputs other than error and cs are combinational from cs and the inputs listed above only.

Reset
REQ-031 rst=0 SHALL immediately force cs=IDLE, error=0, f_q=000, counters=0, and the registered go history to 0; all outputs become 0.
REQ-032 Reset asserted mid-operation SHALL abort with no done pulse and no output load.

Configuration
REQ-033 Macro CALC_SEQ_TIMEOUT_EN defined: a wait counter clears on entry to CALC_WAIT/DIV_WAIT and increments each waiting cycle; after TIMEOUT_CYC cycles without done or err, the next state is ERROR.
REQ-034 Macro undefined: no timeout counter is built; CALC_WAIT and DIV_WAIT wait indefinitely.

Verification
REQ-035 f=000, go rises, done_calc high 3 cycles after go_calc -> op_calc=00, sel_l=01/en_out_l in that cycle, done pulse one cycle later, error=0.
REQ-036 f=110, MUL_LAT=2 -> sel_square=1 from MUL_SET to MUL_LOAD, 2 cycles in MUL_WAIT, en_out_h=en_out_l=1 with sel_l=10, then done.
REQ-037 f=011, err_div=1 in DIV_WAIT -> ERROR, error=1, no en_out_*, no done; next go with f=000 clears error in LOAD.
REQ-038 f=111 -> LOAD, DECODE, ERROR, IDLE; error=1, go_calc and go_div never asserted.
REQ-039 go held high through DONE -> exactly one operation; rst=0 during CALC_WAIT -> cs=0 immediately, no done.
REQ-040 With CALC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=4, done_calc held 0 -> ERROR after 4 CALC_WAIT cycles; without the macro -> remains in CALC_WAIT for 100 or more cycles.

Source files
------------

// File: rtl/calc_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl_if
// Handshake/control bundle between the calculator sequencer and its datapath.
//
// Signals:
//   go          start request (rising-edge qualified by the sequencer)
//   f[2:0]      opcode
//   done_calc   add/sub unit result valid
//   done_div    divider result valid
//   err_div     divider error (divide by zero)
//   en_f/x/y    opcode/operand register load enables
//   go_calc     add/sub unit start pulse
//   go_div      divider start pulse
//   op_calc     add/sub unit operation: 00 add, 01 sub, 10 inc, 11 dec
//   sel_square  multiplier B operand select: 0 Y, 1 X
//   sel_h/sel_l output mux selects
//   en_out_h/l  output register loads
//   done        completion pulse
//   busy        operation in flight
//   error       sticky fault flag
//   cs[3:0]     current sequencer state
//
// Modports:
//   slave  - the sequencer (consumes go/f/unit status, drives controls)
//   master - the environment driving the sequencer
// ---------------------------------------------------------------------------
interface calc_seq_ctrl_if;
    logic       go;
    logic [2:0] f;
    logic       done_calc;
    logic       done_div;
    logic       err_div;
    logic       en_f;
    logic       en_x;
    logic       en_y;
    logic       go_calc;
    logic       go_div;
    logic [1:0] op_calc;
    logic       sel_square;
    logic       sel_h;
    logic [1:0] sel_l;
    logic       en_out_h;
    logic       en_out_l;
    logic       done;
    logic       busy;
    logic       error;
    logic [3:0] cs;

    modport slave (
        input  go, f, done_calc, done_div, err_div,
        output en_f, en_x, en_y, go_calc, go_div, op_calc, sel_square,
               sel_h, sel_l, en_out_h, en_out_l, done, busy, error, cs
    );

    modport master (
        output go, f, done_calc, done_div, err_div,
        input  en_f, en_x, en_y, go_calc, go_div, op_calc, sel_square,
               sel_h, sel_l, en_out_h, en_out_l, done, busy, error, cs
    );
endinterface

// File: rtl/calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// calc_seq_ctrl
// Control sequencer for a small calculator datapath. A rising edge on go
// loads the opcode/operands, then the opcode selects the add/sub unit, the
// fixed-latency multiplier or the divider; the result is steered into the
// output registers and done pulses. Illegal opcodes and divider errors end
// in ERROR, which sets a sticky error flag cleared by the next LOAD.
//
// Parameters:
//   MUL_LAT      multiplier wait cycles between issue and result load (1..15)
//   TIMEOUT_CYC  max wait cycles on done_calc/done_div (1..65535)
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   io_bus   calc_seq_ctrl_if.slave (go/f/unit status in, controls out)
//
// Configuration:
//   CALC_SEQ_TIMEOUT_EN  when defined, CALC_WAIT/DIV_WAIT give up after
//                        TIMEOUT_CYC cycles and go to ERROR; when undefined
//                        no timeout counter exists and the waits are unbounded.
//
// All outputs except error and cs are combinational from the state register,
// the captured opcode and the unit status inputs.
// ---------------------------------------------------------------------------
module calc_seq_ctrl #(
    parameter int unsigned MUL_LAT     = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    calc_seq_ctrl_if.slave   io_bus
);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StLoad     = 4'd1,
        StDecode   = 4'd2,
        StCalcGo   = 4'd3,
        StCalcWait = 4'd4,
        StMulSet   = 4'd5,
        StMulWait  = 4'd6,
        StMulLoad  = 4'd7,
        StDivGo    = 4'd8,
        StDivWait  = 4'd9,
        StDone     = 4'd10,
        StError    = 4'd11
    } state_e;

    localparam logic [3:0] MulCntLoad = 4'(MUL_LAT - 1);

    // Out-of-range parameters have no legal behaviour; this branch exists only
    // so the range is stated next to the logic that depends on it.
    if (MUL_LAT < 1 || MUL_LAT > 15 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535)
    begin : g_bad_param
    end

    // ------------------------------------------------------------------
    // State and next-state signals
    // ------------------------------------------------------------------
    state_e     r_cs;
    state_e     w_ns;
    logic       r_go;
    logic [2:0] r_f;
    logic [3:0] r_mul_cnt;
    logic [3:0] w_mul_cnt_d;
    logic       r_error;
    logic       w_error_d;
    logic       w_go_rise;
    logic       w_timeout;
    logic       w_is_square;
    logic [1:0] w_op_dec;

    // Output drivers
    logic       w_en_f;
    logic       w_en_x;
    logic       w_en_y;
    logic       w_go_calc;
    logic       w_go_div;
    logic [1:0] w_op_calc;
    logic       w_sel_square;
    logic       w_sel_h;
    logic [1:0] w_sel_l;
    logic       w_en_out_h;
    logic       w_en_out_l;
    logic       w_done;
    logic       w_busy;

    assign w_go_rise   = io_bus.go & ~r_go;
    assign w_is_square = (r_f == 3'b110);

    // add/sub unit operation from the captured opcode; non-calc opcodes map
    // to 00 so the field is quiet outside the calc path anyway.
    always_comb begin
        w_op_dec = 2'b00;
        unique case (r_f)
            3'b001:  w_op_dec = 2'b01;
            3'b100:  w_op_dec = 2'b10;
            3'b101:  w_op_dec = 2'b11;
            default: w_op_dec = 2'b00;
        endcase
    end

    // ------------------------------------------------------------------
    // Optional wait timeout
    // ------------------------------------------------------------------
`ifdef CALC_SEQ_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYC - 1);

    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_cnt_d;

    // Counts cycles spent in a wait state; held at zero elsewhere, so it is
    // already clear on entry to CALC_WAIT/DIV_WAIT.
    always_comb begin
        w_wait_cnt_d = 16'd0;
        if (r_cs == StCalcWait || r_cs == StDivWait) begin
            w_wait_cnt_d = r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= 16'd0;
        end else begin
            r_wait_cnt <= w_wait_cnt_d;
        end
    end

    // Asserted during the last permitted waiting cycle.
    assign w_timeout = (r_wait_cnt == TimeoutLast);
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cs      <= StIdle;
            r_go      <= 1'b0;
            r_f       <= 3'b000;
            r_mul_cnt <= 4'd0;
            r_error   <= 1'b0;
        end else begin
            r_cs      <= w_ns;
            r_go      <= io_bus.go;
            r_mul_cnt <= w_mul_cnt_d;
            r_error   <= w_error_d;
            if (r_cs == StLoad) begin
                r_f <= io_bus.f;
            end
        end
    end

    // error is cleared as LOAD is entered and set as ERROR is entered, so it
    // reads 0 during LOAD and 1 during ERROR.
    always_comb begin
        w_error_d = r_error;
        if (w_ns == StLoad) begin
            w_error_d = 1'b0;
        end else if (w_ns == StError) begin
            w_error_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ns         = r_cs;
        w_mul_cnt_d  = r_mul_cnt;
        w_en_f       = 1'b0;
        w_en_x       = 1'b0;
        w_en_y       = 1'b0;
        w_go_calc    = 1'b0;
        w_go_div     = 1'b0;
        w_op_calc    = 2'b00;
        w_sel_square = 1'b0;
        w_sel_h      = 1'b0;
        w_sel_l      = 2'b00;
        w_en_out_h   = 1'b0;
        w_en_out_l   = 1'b0;
        w_done       = 1'b0;

        case (r_cs)
            StIdle: begin
                if (w_go_rise) begin
                    w_ns = StLoad;
                end
            end

            StLoad: begin
                w_en_f = 1'b1;
                w_en_x = 1'b1;
                w_en_y = 1'b1;
                w_ns   = StDecode;
            end

            StDecode: begin
                w_op_calc = w_op_dec;
                unique case (r_f)
                    3'b000, 3'b001, 3'b100, 3'b101: w_ns = StCalcGo;
                    3'b010, 3'b110:                 w_ns = StMulSet;
                    3'b011:                         w_ns = StDivGo;
                    default:                        w_ns = StError;
                endcase
            end

            StCalcGo: begin
                w_op_calc = w_op_dec;
                w_go_calc = 1'b1;
                w_ns      = StCalcWait;
            end

            StCalcWait: begin
                w_op_calc = w_op_dec;
                if (io_bus.done_calc) begin
                    w_sel_l    = 2'b01;
                    w_en_out_l = 1'b1;
                    w_ns       = StDone;
                end else if (w_timeout) begin
                    w_ns = StError;
                end
            end

            StMulSet: begin
                w_sel_square = w_is_square;
                w_mul_cnt_d  = MulCntLoad;
                w_ns         = StMulWait;
            end

            // Counter was preloaded with MUL_LAT-1, so leaving on zero gives
            // exactly MUL_LAT cycles here.
            StMulWait: begin
                w_sel_square = w_is_square;
                if (r_mul_cnt == 4'd0) begin
                    w_ns = StMulLoad;
                end else begin
                    w_mul_cnt_d = r_mul_cnt - 4'd1;
                end
            end

            StMulLoad: begin
                w_sel_square = w_is_square;
                w_sel_h      = 1'b0;
                w_sel_l      = 2'b10;
                w_en_out_h   = 1'b1;
                w_en_out_l   = 1'b1;
                w_ns         = StDone;
            end

            StDivGo: begin
                w_go_div = 1'b1;
                w_ns     = StDivWait;
            end

            // err_div wins over done_div: a faulted quotient is never loaded.
            StDivWait: begin
                if (io_bus.err_div) begin
                    w_ns = StError;
                end else if (io_bus.done_div) begin
                    w_sel_h    = 1'b1;
                    w_sel_l    = 2'b11;
                    w_en_out_h = 1'b1;
                    w_en_out_l = 1'b1;
                    w_ns       = StDone;
                end else if (w_timeout) begin
                    w_ns = StError;
                end
            end

            StDone: begin
                w_done = 1'b1;
                w_ns   = StIdle;
            end

            StError: begin
                w_ns = StIdle;
            end

            default: begin
                w_ns = StIdle;
            end
        endcase
    end

    assign w_busy = (r_cs != StIdle);

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign io_bus.en_f       = w_en_f;
    assign io_bus.en_x       = w_en_x;
    assign io_bus.en_y       = w_en_y;
    assign io_bus.go_calc    = w_go_calc;
    assign io_bus.go_div     = w_go_div;
    assign io_bus.op_calc    = w_op_calc;
    assign io_bus.sel_square = w_sel_square;
    assign io_bus.sel_h      = w_sel_h;
    assign io_bus.sel_l      = w_sel_l;
    assign io_bus.en_out_h   = w_en_out_h;
    assign io_bus.en_out_l   = w_en_out_l;
    assign io_bus.done       = w_done;
    assign io_bus.busy       = w_busy;
    assign io_bus.error      = r_error;
    assign io_bus.cs         = r_cs;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_calc_seq_ctrl
// Scoreboard bench for calc_seq_ctrl. Each directed scenario pushes the
// events it expects (cycle stamp plus the full control vector) into a queue;
// a negedge monitor pops and compares whenever the DUT shows an event
// (operand load, unit start, output load, done, square select or ERROR).
// ---------------------------------------------------------------------------
module tb_calc_seq_ctrl;

    localparam int unsigned MulLat     = 2;
    localparam int unsigned TimeoutCyc = 4;

    localparam logic [3:0] CsIdle = 4'd0, CsLoad = 4'd1, CsCalcGo = 4'd3,
                           CsCalcWait = 4'd4, CsMulSet = 4'd5, CsMulWait = 4'd6,
                           CsMulLoad = 4'd7, CsDivGo = 4'd8, CsDivWait = 4'd9,
                           CsDone = 4'd10, CsError = 4'd11, CsDecode = 4'd2;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  cs;
        logic        en_f;
        logic        en_x;
        logic        en_y;
        logic        go_calc;
        logic        go_div;
        logic [1:0]  op_calc;
        logic        sel_square;
        logic        sel_h;
        logic [1:0]  sel_l;
        logic        en_out_h;
        logic        en_out_l;
        logic        done;
        logic        busy;
        logic        error;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    ev_t  exp_q[$];

    calc_seq_ctrl_if bus ();

    calc_seq_ctrl #(
        .MUL_LAT     (MulLat),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic ev_t mk(input int c, input logic [3:0] s);
        ev_t e;
        e      = '0;
        e.cyc  = 32'(c);
        e.cs   = s;
        e.busy = (s != CsIdle);
        return e;
    endfunction

    function automatic ev_t sample();
        ev_t e;
        e.cyc        = 32'(cyc);
        e.cs         = bus.cs;
        e.en_f       = bus.en_f;
        e.en_x       = bus.en_x;
        e.en_y       = bus.en_y;
        e.go_calc    = bus.go_calc;
        e.go_div     = bus.go_div;
        e.op_calc    = bus.op_calc;
        e.sel_square = bus.sel_square;
        e.sel_h      = bus.sel_h;
        e.sel_l      = bus.sel_l;
        e.en_out_h   = bus.en_out_h;
        e.en_out_l   = bus.en_out_l;
        e.done       = bus.done;
        e.busy       = bus.busy;
        e.error      = bus.error;
        return e;
    endfunction

    task automatic push(input ev_t e);
        exp_q.push_back(e);
    endtask

    task automatic push_load(input int c);
        ev_t e;
        e = mk(c, CsLoad);
        e.en_f = 1'b1; e.en_x = 1'b1; e.en_y = 1'b1;
        push(e);
    endtask

    task automatic push_done(input int c);
        ev_t e;
        e = mk(c, CsDone);
        e.done = 1'b1;
        push(e);
    endtask

    task automatic push_error(input int c);
        ev_t e;
        e = mk(c, CsError);
        e.error = 1'b1;
        push(e);
    endtask

    // Advance to just after the rising edge that starts cycle t.
    task automatic at(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cyc %0d)", nm, got, req, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        ev_t obs;
        ev_t e;
        if (bus.en_f || bus.go_calc || bus.go_div || bus.en_out_h || bus.en_out_l ||
            bus.done || bus.sel_square || bus.cs == CsError) begin
            obs = sample();
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: got %h (cs %0d cyc %0d), required none",
                         obs, obs.cs, cyc);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_fail++;
                    $display("FAIL event cs%0d: got %h, required %h (cyc %0d)",
                             e.cs, obs, e, cyc);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    // add/sub/inc/dec with done_calc three cycles after go_calc; go toggled
    // while busy and f changed after capture must both be ignored.
    task automatic run_calc(input logic [2:0] fv, input logic [1:0] op);
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        e = mk(k + 3, CsCalcGo);   e.go_calc = 1'b1; e.op_calc = op; push(e);
        e = mk(k + 6, CsCalcWait); e.en_out_l = 1'b1; e.sel_l = 2'b01; e.op_calc = op; push(e);
        push_done(k + 7);
        at(k);     bus.f = fv; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 2); bus.f = ~fv;
        at(k + 4); bus.go = 1'b1;
        at(k + 5); bus.go = 1'b0;
        at(k + 6); bus.done_calc = 1'b1;
        at(k + 7); bus.done_calc = 1'b0;
        at(k + 9);
    endtask

    task automatic run_mul(input logic sq);
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        if (sq) begin
            e = mk(k + 3, CsMulSet);  e.sel_square = 1'b1; push(e);
            e = mk(k + 4, CsMulWait); e.sel_square = 1'b1; push(e);
            e = mk(k + 5, CsMulWait); e.sel_square = 1'b1; push(e);
        end
        e = mk(k + 6, CsMulLoad);
        e.sel_square = sq; e.sel_l = 2'b10; e.en_out_h = 1'b1; e.en_out_l = 1'b1;
        push(e);
        push_done(k + 7);
        at(k);     bus.f = sq ? 3'b110 : 3'b010; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 9);
    endtask

    // Division; with err the error and done_div arrive together to show
    // err_div has priority.
    task automatic run_div(input logic err);
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        e = mk(k + 3, CsDivGo); e.go_div = 1'b1; push(e);
        if (err) begin
            push_error(k + 6);
        end else begin
            e = mk(k + 5, CsDivWait);
            e.sel_h = 1'b1; e.sel_l = 2'b11; e.en_out_h = 1'b1; e.en_out_l = 1'b1;
            push(e);
            push_done(k + 6);
        end
        at(k);     bus.f = 3'b011; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 5); bus.done_div = 1'b1; bus.err_div = err;
        at(k + 6); bus.done_div = 1'b0; bus.err_div = 1'b0;
        if (err) begin
            chk("div_err_state", 32'(bus.cs), 32'(CsError));
            at(k + 7);
            chk("div_err_idle", 32'(bus.cs), 32'(CsIdle));
            chk("div_err_sticky", 32'(bus.error), 32'd1);
        end
        at(k + 9);
    endtask

    task automatic run_illegal();
        int k;
        k = cyc + 2;
        push_load(k + 1);
        push_error(k + 3);
        at(k);     bus.f = 3'b111; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 2); chk("illegal_decode", 32'(bus.cs), 32'(CsDecode));
        at(k + 4); chk("illegal_idle", 32'(bus.cs), 32'(CsIdle));
        at(k + 5); chk("illegal_sticky", 32'(bus.error), 32'd1);
    endtask

    // go stays high through DONE and well into IDLE: exactly one operation.
    task automatic run_go_held();
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        e = mk(k + 3, CsCalcGo);   e.go_calc = 1'b1; push(e);
        e = mk(k + 4, CsCalcWait); e.en_out_l = 1'b1; e.sel_l = 2'b01; push(e);
        push_done(k + 5);
        at(k);      bus.f = 3'b000; bus.go = 1'b1;
        at(k + 4);  bus.done_calc = 1'b1;
        at(k + 5);  bus.done_calc = 1'b0;
        at(k + 12); chk("go_held_idle", 32'(bus.cs), 32'(CsIdle));
        bus.go = 1'b0;
        at(k + 14);
    endtask

    task automatic run_reset_mid();
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        e = mk(k + 3, CsCalcGo); e.go_calc = 1'b1; push(e);
        at(k);     bus.f = 3'b000; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 5);
        chk("pre_reset_wait", 32'(bus.cs), 32'(CsCalcWait));
        rst_n = 1'b0;
        bus.done_calc = 1'b1;
        #1;
        chk("reset_cs", 32'(bus.cs), 32'(CsIdle));
        chk("reset_en_out_l", 32'(bus.en_out_l), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        at(k + 7); rst_n = 1'b1; bus.done_calc = 1'b0;
        at(k + 10);
    endtask

    task automatic run_timeout();
        int  k;
        ev_t e;
        k = cyc + 2;
        push_load(k + 1);
        e = mk(k + 3, CsCalcGo); e.go_calc = 1'b1; push(e);
`ifdef CALC_SEQ_TIMEOUT_EN
        push_error(k + 8);
        at(k);     bus.f = 3'b000; bus.go = 1'b1;
        at(k + 1); bus.go = 1'b0;
        at(k + 7); chk("timeout_last_wait", 32'(bus.cs), 32'(CsCalcWait));
        at(k + 9); chk("timeout_idle", 32'(bus.cs), 32'(CsIdle));
        chk("timeout_error", 32'(bus.error), 32'd1);
`else
        at(k);       bus.f = 3'b000; bus.go = 1'b1;
        at(k + 1);   bus.go = 1'b0;
        at(k + 104); chk("no_timeout_wait", 32'(bus.cs), 32'(CsCalcWait));
        chk("no_timeout_busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        at(k + 106); rst_n = 1'b1;
`endif
        at(cyc + 3);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        bus.go        = 1'b0;
        bus.f         = 3'b000;
        bus.done_calc = 1'b0;
        bus.done_div  = 1'b0;
        bus.err_div   = 1'b0;
        rst_n         = 1'b1;
        #1 rst_n      = 1'b0;
        #2;
        chk("rst_cs", 32'(bus.cs), 32'(CsIdle));
        chk("rst_error", 32'(bus.error), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_outs", {22'd0, bus.en_f, bus.en_x, bus.en_y, bus.go_calc, bus.go_div,
                         bus.sel_square, bus.sel_h, bus.en_out_h, bus.en_out_l, bus.done},
            32'd0);
        at(2);
        rst_n = 1'b1;
        at(4);

        run_calc(3'b000, 2'b00);
        run_calc(3'b001, 2'b01);
        run_calc(3'b100, 2'b10);
        run_calc(3'b101, 2'b11);
        run_mul(1'b1);
        run_mul(1'b0);
        run_div(1'b0);
        run_div(1'b1);
        run_calc(3'b000, 2'b00);
        run_illegal();
        run_calc(3'b000, 2'b00);
        run_go_held();
        run_reset_mid();
        run_timeout();

        at(cyc + 3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
